// File: rtl/lpif_credit_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : lpif_credit_tx_buffer
// Description : Downstream word FIFO with credit-gated pop toward the PHY
//               concat block, online/offline sequencing and a debug word.
// Revision    : 1.0 - initial release
// ============================================================================
module lpif_credit_tx_buffer #(
    parameter int DATA_WIDTH   = 546,
    parameter int DEPTH        = 16,
    parameter int CREDIT_WIDTH = 8,
    parameter int AFULL_THRESH = 12
) (
    input  logic                    clk_wr,
    input  logic                    rst_wr,
    input  logic                    tx_online,
    input  logic [CREDIT_WIDTH-1:0] init_downstream_credit,
    input  logic                    push_valid,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    credit_return,
    output logic                    tx_downstream_valid,
    output logic [DATA_WIDTH-1:0]   tx_downstream_data,
    output logic                    almost_full,
    output logic                    overflow,
    output logic                    credit_err,
    output logic [31:0]             debug_status
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_fill_w = c_ptr_w + 1;

    localparam logic [c_fill_w-1:0] c_fill_full  = c_fill_w'(DEPTH);
    localparam logic [c_fill_w-1:0] c_fill_afull = c_fill_w'(AFULL_THRESH);

    localparam logic [1:0] c_st_offline = 2'd0;
    localparam logic [1:0] c_st_load    = 2'd1;
    localparam logic [1:0] c_st_active  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic                    r_online_q;
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_fill_w-1:0]     r_fill;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic [CREDIT_WIDTH-1:0] w_credit_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_credit_max;
    logic [7:0] w_fill_dbg;
    logic [7:0] w_credit_dbg;

    assign w_full       = (r_fill == c_fill_full);
    assign w_empty      = (r_fill == '0);
    assign w_credit_max = (r_credit == '1);
    assign w_push       = push_valid & ~w_full;
    // Pop is held off on the edge that takes the link offline so nothing is
    // emitted after tx_online has dropped.
    assign w_pop        = (r_state == c_st_active) & tx_online & ~w_empty & (r_credit != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_offline: if (tx_online && !r_online_q) w_state_nxt = c_st_load;
            c_st_load:    w_state_nxt = tx_online ? c_st_active : c_st_offline;
            c_st_active:  if (!tx_online) w_state_nxt = c_st_offline;
            default:      w_state_nxt = c_st_offline;
        endcase
    end

    always_comb begin
        w_credit_nxt = r_credit;
        case (r_state)
            c_st_load: w_credit_nxt = tx_online ? init_downstream_credit : '0;
            c_st_active: begin
                if (!tx_online) begin
                    w_credit_nxt = '0;
                end else if (w_pop && !credit_return) begin
                    w_credit_nxt = r_credit - CREDIT_WIDTH'(1);
                end else if (credit_return && !w_pop && !w_credit_max) begin
                    w_credit_nxt = r_credit + CREDIT_WIDTH'(1);
                end
            end
            default: w_credit_nxt = r_credit;
        endcase
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state             <= c_st_offline;
            r_online_q          <= 1'b0;
            r_wr_ptr            <= '0;
            r_rd_ptr            <= '0;
            r_fill              <= '0;
            r_credit            <= '0;
            overflow            <= 1'b0;
            credit_err          <= 1'b0;
            tx_downstream_valid <= 1'b0;
            tx_downstream_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_online_q <= tx_online;
            r_credit   <= w_credit_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_push && !w_pop)      r_fill <= r_fill + c_fill_w'(1);
            else if (w_pop && !w_push) r_fill <= r_fill - c_fill_w'(1);
            if (push_valid && w_full) overflow <= 1'b1;
            if ((r_state == c_st_active) && credit_return && !w_pop && w_credit_max)
                credit_err <= 1'b1;
            tx_downstream_valid <= w_pop;
            if (w_pop) tx_downstream_data <= r_mem[r_rd_ptr];
        end
    end

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk_wr) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    always_comb begin
        w_fill_dbg                 = '0;
        w_fill_dbg[c_fill_w-1:0]   = r_fill;
        w_credit_dbg               = '0;
        w_credit_dbg[CREDIT_WIDTH-1:0] = r_credit;
    end

    assign almost_full  = (r_fill >= c_fill_afull);
    assign debug_status = {r_state, credit_err, overflow, 12'h000, w_fill_dbg, w_credit_dbg};

endmodule
`default_nettype wire

// File: tb/tb_lpif_credit_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpif_credit_tx_buffer
// Description : Directed self-checking bench for lpif_credit_tx_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpif_credit_tx_buffer;

    localparam int DW = 546;
    localparam int CW = 8;

    logic          clk_wr = 1'b0;
    logic          rst_wr = 1'b1;
    logic          tx_online = 1'b0;
    logic [CW-1:0] init_downstream_credit = '0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          credit_return = 1'b0;
    logic          tx_downstream_valid;
    logic [DW-1:0] tx_downstream_data;
    logic          almost_full;
    logic          overflow;
    logic          credit_err;
    logic [31:0]   debug_status;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int first_push_cyc = 0;
    logic [DW-1:0] got_q [$];
    int            got_cyc [$];

    lpif_credit_tx_buffer #(
        .DATA_WIDTH(DW), .DEPTH(16), .CREDIT_WIDTH(CW), .AFULL_THRESH(12)
    ) u_dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .tx_online(tx_online),
        .init_downstream_credit(init_downstream_credit),
        .push_valid(push_valid), .push_data(push_data), .credit_return(credit_return),
        .tx_downstream_valid(tx_downstream_valid), .tx_downstream_data(tx_downstream_data),
        .almost_full(almost_full), .overflow(overflow), .credit_err(credit_err),
        .debug_status(debug_status)
    );

    always #5 clk_wr = ~clk_wr;

    always @(posedge clk_wr) cyc <= cyc + 1;

    always @(negedge clk_wr) begin
        if (tx_downstream_valid) begin
            got_q.push_back(tx_downstream_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [DW-1:0] word(input int i);
        logic [575:0] t;
        t = {18{32'(i) ^ 32'h5A5A_0000}};
        t[575:560] = 16'(i * 3 + 1);
        return t[DW-1:0];
    endfunction

    task automatic push_words(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            push_valid = 1'b1;
            push_data  = word(base + i);
            tick();
            if (i == 0) first_push_cyc = cyc;
        end
        push_valid = 1'b0;
    endtask

    task automatic check_got(input string tag, input int base, input int n);
        check({tag, "_count"}, DW'(got_q.size()), DW'(n));
        for (int i = 0; i < n; i++)
            check({tag, "_word"}, (i < got_q.size()) ? got_q[i] : '0, word(base + i));
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic go_online(input logic [CW-1:0] init);
        init_downstream_credit = init;
        tx_online = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_valid", DW'(tx_downstream_valid), '0);
        check("rst_data", tx_downstream_data, '0);
        check("rst_debug", DW'(debug_status), '0);
        check("rst_flags", DW'({almost_full, overflow, credit_err}), '0);
        rst_wr = 1'b0;
        tick();

        // 1: init 4, six pushes, only four leave
        go_online(8'd4);
        check("t1_state", DW'(debug_status[31:30]), DW'(2));
        check("t1_credit_load", DW'(debug_status[7:0]), DW'(4));
        push_words(0, 6);
        repeat (3) tick();
        check("t1_latency", DW'((got_cyc.size() > 0) ? got_cyc[0] : -1), DW'(first_push_cyc + 1));
        check_got("t1", 0, 4);
        check("t1_credit", DW'(debug_status[7:0]), DW'(0));
        check("t1_fill", DW'(debug_status[15:8]), DW'(2));

        // 2: two returned credits release D4, D5
        for (int i = 0; i < 2; i++) begin
            credit_return = 1'b1;
            tick();
            credit_return = 1'b0;
            tick();
        end
        repeat (3) tick();
        check_got("t2", 4, 2);
        check("t2_credit", DW'(debug_status[7:0]), DW'(0));
        check("t2_fill", DW'(debug_status[15:8]), DW'(0));
        check("t2_afull", DW'(almost_full), '0);

        // 3: offline fill to full, 17th word dropped
        tx_online = 1'b0;
        tick();
        check("t3_state", DW'(debug_status[31:30]), DW'(0));
        for (int i = 0; i < 17; i++) begin
            push_valid = 1'b1;
            push_data  = word(100 + i);
            tick();
            if (i == 10) check("t3_afull_11", DW'(almost_full), '0);
            if (i == 11) check("t3_afull_12", DW'(almost_full), DW'(1));
            if (i == 15) check("t3_ovf_16", DW'(overflow), '0);
        end
        push_valid = 1'b0;
        check("t3_fill", DW'(debug_status[15:8]), DW'(16));
        check("t3_ovf", DW'(overflow), DW'(1));
        check("t3_dbg_ovf", DW'(debug_status[28]), DW'(1));
        check("t3_valid", DW'(tx_downstream_valid), '0);

        // Asynchronous mid-operation reset
        rst_wr = 1'b1;
        #1;
        check("arst_debug", DW'(debug_status), '0);
        check("arst_flags", DW'({almost_full, overflow}), '0);
        tick();
        rst_wr = 1'b0;
        tick();

        // 4: credit_return at max credit
        go_online(8'd255);
        check("t4_credit_load", DW'(debug_status[7:0]), DW'(255));
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("t4_credit", DW'(debug_status[7:0]), DW'(255));
        check("t4_err", DW'(credit_err), DW'(1));
        check("t4_dbg_err", DW'(debug_status[29]), DW'(1));

        // 5: credit 3, pop and return in same cycle
        tx_online = 1'b0;
        tick();
        push_words(200, 3);
        got_q.delete();
        got_cyc.delete();
        go_online(8'd3);
        check("t5_credit_load", DW'(debug_status[7:0]), DW'(3));
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        check("t5_valid", DW'(tx_downstream_valid), DW'(1));
        check("t5_credit_same", DW'(debug_status[7:0]), DW'(3));
        repeat (4) tick();
        check_got("t5", 200, 3);
        check("t5_credit_end", DW'(debug_status[7:0]), DW'(1));

        // 6: offline with 5 buffered, then re-online with init 2
        push_words(300, 6);
        check("t6_fill_pre", DW'(debug_status[15:8]), DW'(5));
        tx_online = 1'b0;
        tick();
        check("t6_valid", DW'(tx_downstream_valid), '0);
        check("t6_state", DW'(debug_status[31:30]), DW'(0));
        check("t6_credit", DW'(debug_status[7:0]), DW'(0));
        check("t6_fill", DW'(debug_status[15:8]), DW'(5));
        go_online(8'd2);
        repeat (4) tick();
        check_got("t6", 300, 3);
        check("t6_fill_end", DW'(debug_status[15:8]), DW'(3));
        check("t6_credit_end", DW'(debug_status[7:0]), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
